// File: rtl/sat_ctr_table_if.sv
// Bus bundle for sat_ctr_table: read port, update port and flush control.
// The master modport drives requests; the slave modport is the counter table.
interface sat_ctr_table_if #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned WIDTH   = 2
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_ctr;
  logic             rd_taken;
  logic             upd_en;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             clr;
  logic             busy;

  modport master (
    output rd_en, rd_idx, upd_en, upd_idx, upd_taken, clr,
    input  rd_valid, rd_ctr, rd_taken, busy
  );

  modport slave (
    input  rd_en, rd_idx, upd_en, upd_idx, upd_taken, clr,
    output rd_valid, rd_ctr, rd_taken, busy
  );
endinterface

// File: rtl/sat_ctr_table.sv
// Table of saturating up/down counters with a registered read port, an update port
// and a multi-cycle flush sweep. Define SAT_CTR_TABLE_BYPASS_EN to forward same-index updates.
module sat_ctr_table #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned INIT    = 1 << (WIDTH - 1)
) (
  input logic             clk,
  input logic             rst_n,
  sat_ctr_table_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_table [ENTRIES];
  logic             r_rd_valid;
  logic [WIDTH-1:0] r_rd_ctr;

  logic [WIDTH-1:0] w_upd_old;
  logic [WIDTH-1:0] w_upd_new;
  logic [WIDTH-1:0] w_rd_data;

  assign w_upd_old = r_table[bus.upd_idx];

  always_comb begin
    w_upd_new = w_upd_old;
    if (bus.upd_taken) begin
      if (w_upd_old != MAX_V) w_upd_new = w_upd_old + 1'b1;
    end else begin
      if (w_upd_old != '0) w_upd_new = w_upd_old - 1'b1;
    end
  end

`ifdef SAT_CTR_TABLE_BYPASS_EN
  // Forward a same-index update so the read sees the post-step value.
  assign w_rd_data = (bus.upd_en && (bus.upd_idx == bus.rd_idx)) ? w_upd_new
                                                                  : r_table[bus.rd_idx];
`else
  assign w_rd_data = r_table[bus.rd_idx];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) r_table[i] <= INIT_V;
      r_state    <= StIdle;
      r_ptr      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_ctr   <= '0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_ctr <= (r_state == StClear) ? INIT_V : w_rd_data;

      unique case (r_state)
        StIdle: begin
          if (bus.upd_en) r_table[bus.upd_idx] <= w_upd_new;
          if (bus.clr) begin
            r_state <= StClear;
            r_ptr   <= '0;
          end
        end
        StClear: begin
          r_table[r_ptr] <= INIT_V;
          r_ptr          <= r_ptr + 1'b1;
          if (r_ptr == LAST_IDX) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_ctr   = r_rd_ctr;
  assign bus.rd_taken = r_rd_ctr[WIDTH-1];
  assign bus.busy     = (r_state == StClear);
endmodule

// File: doc/sat_ctr_table.md
# sat_ctr_table

Parametrised table of saturating up/down counters for the branch predictor: a generalised, stateful successor to the single-counter saturating step. Holds `ENTRIES` counters of `WIDTH` bits in flops. Provides a registered read port for the fetch-stage prediction and an update port for the resolve stage. A multi-cycle flush sweep returns every counter to its initial value.

## Interface
- `ENTRIES`, 32: number of counters; power of two, ≥ 2. `IDX_W = $clog2(ENTRIES)` is derived locally.
- `WIDTH`, 2: counter width in bits, ≥ 1.
- `INIT`, `1 << (WIDTH-1)`: value loaded on reset and on flush (weakly taken); must be < 2^WIDTH.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_en`  in  1  read request.
- `rd_idx`  in  IDX_W  read index.
- `rd_valid`  out  1  read data valid (one cycle after `rd_en`).
- `rd_ctr`  out  WIDTH  counter value returned.
- `rd_taken`  out  1  prediction; equals `rd_ctr[WIDTH-1]`.
- `upd_en`  in  1  update request.
- `upd_idx`  in  IDX_W  update index.
- `upd_taken`  in  1  1 = increment, 0 = decrement.
- `clr`  in  1  flush request; one-cycle pulse is sufficient.
- `busy`  out  1  flush sweep in progress.

## Operation
- Counters are unsigned, `WIDTH` bits.
- Increment saturates at 2^WIDTH−1.
- Decrement saturates at 0.
- No wrap-around under any input sequence.
- **Update:** if `upd_en` is high and state is IDLE, `table[upd_idx]` takes its saturated step at the edge.
- **Read:** if `rd_en` is high, `rd_ctr` is loaded with `table[rd_idx]` at the edge and `rd_valid` is 1 for the following cycle.
  - If `rd_en` is low, `rd_valid` is 0 and `rd_ctr` holds its last value.
- **Same-index read and update in the same cycle:** behaviour is set by the configuration below.
- **FSM states:** IDLE and CLEAR.
  - IDLE → CLEAR when `clr` is sampled high. The sweep pointer `ptr` is set to 0.
  - In CLEAR, each cycle writes `table[ptr] <= INIT` and increments `ptr`.
  - After the write at `ptr == ENTRIES-1`, the FSM returns to IDLE.
- **During CLEAR:**
  - `upd_en` is dropped with no effect.
  - `clr` is ignored.
  - Reads complete normally in timing, but `rd_ctr` is loaded with `INIT`, so the flushed table is visible immediately.
- An update sampled in the same cycle as `clr` (state still IDLE) is applied, then overwritten by the sweep.
- `busy` is high iff state is CLEAR.

## Timing
- **Reset (asynchronous, `rst_n` = 0):**
  - All entries = `INIT`.
  - `rd_valid` = 0, `rd_ctr` = 0, `busy` = 0.
  - State = IDLE, `ptr` = 0.
  - Reset asserted mid-sweep aborts the sweep. Every entry is `INIT` regardless of progress.
- **Read latency:** 1 cycle, fully pipelined; a new read is accepted every cycle.
- **Update latency:** the new value is visible to a read issued the next cycle.
- **Flush:**
  - `clr` is high at edge N.
  - `busy` is high from after edge N through edge N+ENTRIES, i.e. for exactly `ENTRIES` cycles.
  - Updates are accepted again at edge N+ENTRIES+1.
- No combinational path from any input to any output.

## Configuration
- Macro `SAT_CTR_TABLE_BYPASS_EN` controls same-cycle read/update at the same index in IDLE.
  - **Defined:** `rd_ctr` returns the post-update value, i.e. the saturated step of the old value. The update is forwarded to the read.
  - **Undefined:** `rd_ctr` returns the pre-update value. The table still takes the update.
- Behaviour at different indices, and all CLEAR-state behaviour, is identical in both builds.

## Test plan
Bench parameters: `ENTRIES`=16, `WIDTH`=2, `INIT`=2 unless noted.
- **Reset:** drive `rst_n` low, then read all 16 indices → each `rd_ctr` = 2, `rd_taken` = 1; `busy` = 0.
- **Saturation:** 3 increments to idx 5 → read gives 3. 5 decrements → read gives 0; `rd_taken` = 0.
- **Flush:**
  - Increment idx 3 to 3 and decrement idx 9 to 0, then pulse `clr` → `busy` high for exactly 16 cycles.
  - Updates issued during the sweep leave no trace.
  - Reads of idx 3 and 9 during and after the sweep return 2.
- **Same-cycle read and update, idx 7 at 2, `upd_taken` = 1:**
  - Bypass build: `rd_ctr` = 3.
  - Non-bypass build: `rd_ctr` = 2.
  - Both builds: a following read returns 3.
- **Reset mid-sweep:** assert `rst_n` low at sweep cycle 6 → `busy` = 0 immediately. All entries read 2; the FSM accepts a new `clr`.
- **Width generalisation** (`WIDTH`=3, `INIT`=4): 5 increments → 7; 9 decrements → 0. `rd_taken` switches at the 4↔3 boundary.
